// File: rtl/as_spoof_check_32bit.sv
// rtl/as_spoof_check_32bit.sv - IPv4 address capture and per-port MAC/IP anti-spoof verdict
module as_spoof_check_32bit #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int          NUM_IQ_BITS    = 3,
  parameter logic [15:0] IPV4_ETHERTYPE = 16'h0800
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  input  logic                   in_wr,
  input  logic [47:0]            src_mac,
  input  logic [15:0]            ethertype,
  input  logic                   eth_done,
  input  logic [NUM_IQ_BITS-1:0] src_port,
  input  logic                   tbl_wr_en,
  input  logic [NUM_IQ_BITS-1:0] tbl_wr_addr,
  input  logic [47:0]            tbl_wr_mac,
  input  logic [31:0]            tbl_wr_ip,
  input  logic                   tbl_wr_valid,
  output logic [31:0]            src_ip,
  output logic [31:0]            dst_ip,
  output logic                   ip_done,
  output logic                   check_done,
  output logic                   spoof_drop,
  output logic [31:0]            drop_count
);

  localparam int NUM_ENTRIES = 2 ** NUM_IQ_BITS;
  localparam logic [CTRL_WIDTH-1:0] CTRL_HDR = CTRL_WIDTH'(2);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    CHECK,
    SHORT,
    WAIT_EOP
  } state_t;

  state_t state;
  logic [3:0]  word_cnt;
  logic        armed;
  logic        eop_seen;
  logic        ip_mode;
  logic [15:0] src_ip_hi_q;
  logic [15:0] src_ip_lo_q;
  logic [15:0] dst_ip_hi_q;

  logic [NUM_ENTRIES-1:0] tbl_valid;
  logic [47:0]            tbl_mac [NUM_ENTRIES];
  logic [31:0]            tbl_ip  [NUM_ENTRIES];

  logic       data_word;
  logic       eop_word;
  logic [3:0] cnt_next;
  logic       spoof;

  always_comb begin
    data_word = in_wr && (in_ctrl == '0);
    eop_word  = in_wr && (in_ctrl != '0) && (in_ctrl != CTRL_HDR);
    cnt_next  = (word_cnt == 4'hF) ? word_cnt : word_cnt + 4'd1;
    // Entry contents read here are the pre-write values when a write targets the same index.
    spoof     = tbl_valid[src_port] &&
                ((src_mac != tbl_mac[src_port]) ||
                 (ip_mode && (src_ip != tbl_ip[src_port])));
  end

  always_ff @(posedge clk) begin
    if (!reset && tbl_wr_en) begin
      tbl_mac[tbl_wr_addr] <= tbl_wr_mac;
      tbl_ip[tbl_wr_addr]  <= tbl_wr_ip;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      word_cnt    <= '0;
      armed       <= 1'b0;
      eop_seen    <= 1'b0;
      ip_mode     <= 1'b0;
      src_ip_hi_q <= '0;
      src_ip_lo_q <= '0;
      dst_ip_hi_q <= '0;
      tbl_valid   <= '0;
      src_ip      <= '0;
      dst_ip      <= '0;
      ip_done     <= 1'b0;
      check_done  <= 1'b0;
      spoof_drop  <= 1'b0;
      drop_count  <= '0;
    end else begin
      check_done <= 1'b0;

      if (tbl_wr_en) begin
        tbl_valid[tbl_wr_addr] <= tbl_wr_valid;
      end

      if (check_done && spoof_drop && (drop_count != 32'hFFFF_FFFF)) begin
        drop_count <= drop_count + 32'd1;
      end

      case (state)
        IDLE: begin
          // After reset the tail of an interrupted packet must not look like a new packet.
          if (in_wr && (in_ctrl != '0)) begin
            armed <= 1'b1;
          end
          if (data_word && armed) begin
            word_cnt <= 4'd1;
            eop_seen <= 1'b0;
            state    <= COUNT;
          end
        end

        COUNT: begin
          if (data_word) begin
            word_cnt <= cnt_next;
            if (cnt_next == 4'd7) begin
              src_ip_hi_q <= in_data[15:0];
            end
            if (cnt_next == 4'd8) begin
              src_ip_lo_q <= in_data[31:16];
              dst_ip_hi_q <= in_data[15:0];
            end
          end

          if (eth_done && (ethertype != IPV4_ETHERTYPE)) begin
            ip_mode  <= 1'b0;
            eop_seen <= eop_word;
            state    <= CHECK;
          end else if (data_word && (cnt_next == 4'd9)) begin
            src_ip   <= {src_ip_hi_q, src_ip_lo_q};
            dst_ip   <= {dst_ip_hi_q, in_data[31:16]};
            ip_done  <= 1'b1;
            ip_mode  <= 1'b1;
            eop_seen <= 1'b0;
            state    <= CHECK;
          end else if (eop_word) begin
            state <= SHORT;
          end
        end

        CHECK: begin
          check_done <= 1'b1;
          spoof_drop <= spoof;
          if (eop_seen || eop_word) begin
            ip_done <= 1'b0;
            state   <= IDLE;
          end else begin
            state <= WAIT_EOP;
          end
        end

        SHORT: begin
          check_done <= 1'b1;
          spoof_drop <= 1'b1;
          state      <= IDLE;
        end

        WAIT_EOP: begin
          if (eop_word) begin
            ip_done <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/as_spoof_check_32bit.md
Name: as_spoof_check_32bit

Overview:
- Sits directly downstream of the 32-bit Ethernet parser in the anti-spoof pipeline.
- Taps the same 32-bit input bus and takes the parser's src_mac, ethertype, eth_done and src_port outputs.
- Extracts the IPv4 source and destination addresses, then checks src_mac and src_ip against a per-input-port binding table.
- Produces a one-cycle verdict (pass/drop) for the output port lookup stage, plus a saturating drop counter.

Parameters:
DATA_WIDTH, 32, bus width; only 32 is supported
CTRL_WIDTH, DATA_WIDTH/8, ctrl width
NUM_IQ_BITS, 3, source-port width; table has 2**NUM_IQ_BITS entries
IPV4_ETHERTYPE, 16'h0800, ethertype that enables the IP check

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_data  in  32  packet data bus
in_ctrl  in  4  ctrl; 0 = data word, 2 = module header, other nonzero = EOP word
in_wr  in  1  word valid
src_mac  in  48  from Ethernet parser
ethertype  in  16  from Ethernet parser
eth_done  in  1  from Ethernet parser; high from the cycle after data word 4 until EOP
src_port  in  NUM_IQ_BITS  from Ethernet parser
tbl_wr_en  in  1  binding-table write strobe
tbl_wr_addr  in  NUM_IQ_BITS  entry index (= port)
tbl_wr_mac  in  48  bound MAC
tbl_wr_ip  in  32  bound IP
tbl_wr_valid  in  1  entry valid bit to write
src_ip  out  32  captured IPv4 source
dst_ip  out  32  captured IPv4 destination
ip_done  out  1  IP addresses valid; held until EOP
check_done  out  1  one-cycle verdict strobe
spoof_drop  out  1  verdict; meaningful only while check_done is high
drop_count  out  32  saturating count of drop verdicts

Behaviour:
- Reset values: all outputs 0, all table valid bits 0, state IDLE, word counter 0.
- Word counter: increments on each in_wr with in_ctrl==0; the first data word after the module header is word 1.
- IPv4 field capture (32-bit bus):
  - word7[15:0] -> src_ip[31:16]
  - word8[31:16] -> src_ip[15:0]
  - word8[15:0] -> dst_ip[31:16]
  - word9[31:16] -> dst_ip[15:0]
- States:
  - IDLE: on the first in_wr && in_ctrl==0, set count=1 and go to COUNT. Module-header words (ctrl==2) are ignored.
  - COUNT:
    - If eth_done and ethertype!=IPV4_ETHERTYPE, go to CHECK (ip_mode=0).
    - If word 9 is accepted at edge T, src_ip/dst_ip/ip_done register at T+1; go to CHECK (ip_mode=1).
    - If an EOP word arrives before word 9 with ethertype==IPV4 (or before eth_done), go to SHORT.
  - CHECK: for one cycle, read table[src_port] and compute the verdict. Register check_done=1 and spoof_drop for the next cycle. Go to WAIT_EOP (or IDLE if EOP was already seen).
  - SHORT: for one cycle, check_done=1 and spoof_drop=1, then go to IDLE.
  - WAIT_EOP: on in_wr && in_ctrl!=0, clear ip_done and go to IDLE.
- Verdict: drop = entry.valid && (src_mac != entry.mac || (ip_mode && src_ip != entry.ip)). An invalid entry always passes.
- Latency:
  - IPv4: word 9 accepted at edge T -> check_done high during cycle T+2.
  - Non-IP: word 4 accepted at T -> eth_done at T+1 -> CHECK at T+2 -> check_done at T+3.
- Exactly one check_done pulse per packet, including short packets.
- EOP seen while in CHECK: recorded so the next state is IDLE; the verdict is still issued.
- Table write during CHECK to the same index: CHECK uses the old contents; the write takes effect at the edge.
- Simultaneous writes: only one port exists, so no collision arises.
- drop_count increments on check_done && spoof_drop and saturates at 32'hFFFFFFFF.
- Reset mid-packet: returns to IDLE and clears outputs and the table. Remaining words of the interrupted packet are ignored until the next module header plus data word. Such words are treated as a new packet start only after an EOP.

Test Plan:
- Port 3 table {MAC 00:11:22:33:44:55, IP 10.0.0.1, valid}; IPv4 packet from port 3 with matching fields -> src_ip=0x0A000001, dst_ip correct, check_done at word9+2, spoof_drop=0, drop_count=0.
- Same packet with src_ip 10.0.0.2 -> spoof_drop=1, drop_count=1.
- ARP (ethertype 0x0806) from port 3 with wrong MAC -> check_done at word4+3, spoof_drop=1; with correct MAC -> spoof_drop=0, ip_done stays 0.
- Port 5 table entry invalid, arbitrary IPv4 source -> spoof_drop=0.
- IPv4 packet with EOP on word 6 -> exactly one check_done with spoof_drop=1; the next packet is parsed normally.
- drop_count preloaded near saturation via repeated spoofs (or forced to 0xFFFFFFFE) plus 3 drops -> holds at 0xFFFFFFFF.
- Reset asserted at word 5 -> outputs 0, table cleared; the following packet passes.
